// File: rtl/vga_pkg.sv
// Shared timing descriptor type, stock VGA modes, FSM state codes and size helpers
// for the vga_timing_gen raster generator.
package vga_pkg;

   typedef struct packed {
      logic [11:0] h_active;
      logic [11:0] h_fp;
      logic [11:0] h_sync;
      logic [11:0] h_bp;
      logic [11:0] v_active;
      logic [11:0] v_fp;
      logic [11:0] v_sync;
      logic [11:0] v_bp;
      logic        h_pol;
      logic        v_pol;
   } timing_t;

   localparam timing_t TIMING_640X480_60 = '{
      h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96,  h_bp: 12'd48,
      v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,   v_bp: 12'd33,
      h_pol: 1'b0, v_pol: 1'b0
   };

   localparam timing_t TIMING_800X600_60 = '{
      h_active: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
      v_active: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23,
      h_pol: 1'b1, v_pol: 1'b1
   };

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   function automatic int unsigned total_h(timing_t t);
      return 32'(t.h_active) + 32'(t.h_fp) + 32'(t.h_sync) + 32'(t.h_bp);
   endfunction

   function automatic int unsigned total_v(timing_t t);
      return 32'(t.v_active) + 32'(t.v_fp) + 32'(t.v_sync) + 32'(t.v_bp);
   endfunction

   // Pixel address width sized for the larger active area of the two modes.
   function automatic int unsigned addr_w(timing_t a, timing_t b);
      int unsigned ha;
      int unsigned va;
      ha = (a.h_active > b.h_active) ? 32'(a.h_active) : 32'(b.h_active);
      va = (a.v_active > b.v_active) ? 32'(a.v_active) : 32'(b.v_active);
      return $clog2(ha * va);
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with registered active/sync decode.
// Wrap uses the timing in effect now; decode uses the timing of the next cycle.
module vga_axis_cnt import vga_pkg::*; #(
   parameter int unsigned CW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          adv,
   input  logic          run,
   input  logic [31:0]   total,
   input  logic [31:0]   active,
   input  logic [31:0]   sync_lo,
   input  logic [31:0]   sync_hi,
   input  logic          pol,
   output logic [CW-1:0] cnt,
   output logic          last,
   output logic          zero_next,
   output logic          act,
   output logic          sync
);

   logic [CW-1:0] cnt_d;
   logic [31:0]   cnt_w;

   always_comb begin
      last = (32'(cnt) == total - 32'd1);
      if (clr) begin
         cnt_d = '0;
      end else if (adv) begin
         cnt_d = last ? '0 : cnt + CW'(1);
      end else begin
         cnt_d = cnt;
      end
      cnt_w     = 32'(cnt_d);
      zero_next = run && (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         act  <= 1'b0;
         sync <= ~pol;
      end else begin
         cnt  <= cnt_d;
         act  <= run && (cnt_w < active);
         sync <= (run && (cnt_w >= sync_lo) && (cnt_w < sync_hi)) ? pol : ~pol;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode VGA raster timing generator with frame-boundary mode switch and enable.
// Optional linear active-pixel address output under VGA_PIXEL_ADDR_EN.
module vga_timing_gen import vga_pkg::*; #(
   parameter int unsigned CW    = 11,
   parameter timing_t     MODE0 = TIMING_640X480_60,
   parameter timing_t     MODE1 = TIMING_800X600_60
`ifdef VGA_PIXEL_ADDR_EN
   , parameter int unsigned ADDR_W = addr_w(MODE0, MODE1)
`endif
) (
   input  logic              i_VGA_CLOCK,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_mode,
   output logic              o_de,
   output logic              o_hsync,
   output logic              o_vsync,
   output logic [CW-1:0]     o_Sx,
   output logic [CW-1:0]     o_Sy,
   output logic              o_line_start,
   output logic              o_frame_start,
   output logic              o_mode,
`ifdef VGA_PIXEL_ADDR_EN
   output logic [ADDR_W-1:0] o_addr,
`endif
   output logic              o_mode_pending
);

   logic [1:0] state_q, state_d;
   logic       mode_q, mode_d;
   logic       clr, adv, run_d;
   logic       line_q, frame_q, pend_q;
   timing_t    cur_t, nxt_t;
   logic [31:0] h_total, v_total, h_act, v_act, h_slo, v_slo, h_shi, v_shi;
   logic       h_last, v_last, h_zn, v_zn, h_act_q, v_act_q, frame_last;

   always_comb begin
      cur_t = mode_q ? MODE1 : MODE0;
      nxt_t = mode_d ? MODE1 : MODE0;
      h_total = total_h(cur_t);
      v_total = total_v(cur_t);
      h_act   = 32'(nxt_t.h_active);
      v_act   = 32'(nxt_t.v_active);
      h_slo   = h_act + 32'(nxt_t.h_fp);
      v_slo   = v_act + 32'(nxt_t.v_fp);
      h_shi   = h_slo + 32'(nxt_t.h_sync);
      v_shi   = v_slo + 32'(nxt_t.v_sync);
   end

   assign frame_last = h_last && v_last;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      clr     = 1'b0;
      adv     = 1'b0;
      run_d   = 1'b0;
      if (i_rst) begin
         state_d = S_IDLE;
         mode_d  = 1'b0;
         clr     = 1'b1;
      end else begin
         case (state_q)
            S_RUN, S_DRAIN: begin
               adv   = 1'b1;
               run_d = 1'b1;
               if (i_en) begin
                  state_d = S_RUN;
                  if (frame_last) mode_d = i_mode;
               end else if (frame_last) begin
                  // Stop instead of wrapping; a pending mode is picked up at the next enable.
                  state_d = S_IDLE;
                  clr     = 1'b1;
                  run_d   = 1'b0;
               end else begin
                  state_d = S_DRAIN;
               end
            end
            default: begin
               clr = 1'b1;
               if (i_en) begin
                  state_d = S_RUN;
                  mode_d  = i_mode;
                  run_d   = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         endcase
      end
   end

   vga_axis_cnt #(.CW(CW)) u_h (
      .clk       (i_VGA_CLOCK),
      .rst       (i_rst),
      .clr       (clr),
      .adv       (adv),
      .run       (run_d),
      .total     (h_total),
      .active    (h_act),
      .sync_lo   (h_slo),
      .sync_hi   (h_shi),
      .pol       (nxt_t.h_pol),
      .cnt       (o_Sx),
      .last      (h_last),
      .zero_next (h_zn),
      .act       (h_act_q),
      .sync      (o_hsync)
   );

   vga_axis_cnt #(.CW(CW)) u_v (
      .clk       (i_VGA_CLOCK),
      .rst       (i_rst),
      .clr       (clr),
      .adv       (adv && h_last),
      .run       (run_d),
      .total     (v_total),
      .active    (v_act),
      .sync_lo   (v_slo),
      .sync_hi   (v_shi),
      .pol       (nxt_t.v_pol),
      .cnt       (o_Sy),
      .last      (v_last),
      .zero_next (v_zn),
      .act       (v_act_q),
      .sync      (o_vsync)
   );

   always_ff @(posedge i_VGA_CLOCK) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         line_q  <= h_zn;
         frame_q <= h_zn && v_zn;
         pend_q  <= run_d && (i_mode != mode_d);
      end
   end

   assign o_de           = h_act_q && v_act_q;
   assign o_line_start   = line_q;
   assign o_frame_start  = frame_q;
   assign o_mode         = mode_q;
   assign o_mode_pending = pend_q;

`ifdef VGA_PIXEL_ADDR_EN
   logic [ADDR_W-1:0] addr_q;

   always_ff @(posedge i_VGA_CLOCK) begin
      if (i_rst) begin
         addr_q <= '0;
      end else if (h_zn && v_zn) begin
         addr_q <= '0;
      end else if (o_de) begin
         addr_q <= addr_q + ADDR_W'(1);
      end
   end

   assign o_addr = addr_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA core.
- Generates pixel-clock-domain raster timing from timing descriptors: hsync, vsync, data-enable, Sx/Sy, line/frame strobes.
- Supports two selectable video modes; mode switch and enable/disable take effect only at frame boundaries.
- Sits between the pixel clock source and the pixel/pattern pipeline.

Parameters:
- CW, 11, width of the Sx/Sy counters; must hold max(H_TOTAL, V_TOTAL) - 1 for both modes.
- MODE0, TIMING_640X480_60, timing_t descriptor used when i_mode=0.
- MODE1, TIMING_800X600_60, timing_t descriptor used when i_mode=1.

Ports:
- i_VGA_CLOCK  in  1  pixel clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  run request; level-sensitive.
- i_mode  in  1  requested mode (0 = MODE0, 1 = MODE1).
- o_de  out  1  active-video data enable.
- o_hsync  out  1  horizontal sync, polarity per active mode.
- o_vsync  out  1  vertical sync, polarity per active mode.
- o_Sx  out  CW  horizontal position, 0..H_TOTAL-1.
- o_Sy  out  CW  vertical position, 0..V_TOTAL-1.
- o_line_start  out  1  one-cycle pulse when Sx=0.
- o_frame_start  out  1  one-cycle pulse when Sx=0 and Sy=0.
- o_mode  out  1  mode currently in effect.
- o_mode_pending  out  1  i_mode differs from o_mode while running.

Behaviour:
- Totals: H_TOTAL = h_active + h_fp + h_sync + h_bp; V_TOTAL is the vertical equivalent.
- All outputs are registered and mutually aligned: o_de, o_hsync, o_vsync and the strobes decode the same (Sx, Sy) shown on o_Sx/o_Sy in that cycle.
- Decode rules:
  - de = (Sx < h_active) && (Sy < v_active).
  - hsync is active while h_active+h_fp <= Sx < h_active+h_fp+h_sync; active level = h_pol, else ~h_pol.
  - vsync follows the same rule on Sy.
- Advance: Sx increments each cycle. At Sx = H_TOTAL-1, Sx wraps to 0 and Sy increments. At Sy = V_TOTAL-1 with Sx wrapping, Sy wraps to 0.
- Reset (any cycle, including mid-frame): next cycle shows Sx=Sy=0, de=0, line_start=frame_start=0, syncs at inactive level of MODE0, o_mode=0, o_mode_pending=0, FSM in S_IDLE. Reset has priority over all inputs.
- FSM states:
  - S_IDLE: counters held at 0; outputs inactive (de=0, strobes 0, syncs inactive).
    - If i_en=1: latch o_mode <= i_mode and go to S_RUN. In the next cycle the outputs show (0,0) with de=1, line_start=1, frame_start=1.
  - S_RUN: advance every cycle.
    - If i_en=0: go to S_DRAIN without disturbing the counters.
  - S_DRAIN: keep advancing to the end of the current frame.
    - If i_en=1 before the frame end: return to S_RUN with no glitch.
    - At the last pixel of the frame (Sx=H_TOTAL-1, Sy=V_TOTAL-1): go to S_IDLE instead of wrapping.
- Mode switch:
  - o_mode_pending = (i_mode != o_mode) in S_RUN/S_DRAIN; it is 0 in S_IDLE.
  - o_mode updates only on the frame-wrap edge from S_RUN. The first cycle of the new frame is decoded with the new timing.
  - If i_mode toggles back before the wrap, no switch occurs.
- Simultaneous disable and mode change at frame end: go to S_IDLE; the mode is latched at the next enable.
- The decode must never compare against the other mode's totals mid-frame.

Optional Feature:
- Macro: VGA_PIXEL_ADDR_EN.
- When defined:
  - Adds port o_addr (out, ADDR_W = clog2(h_active_max * v_active_max)): linear active-pixel index.
  - Cleared to 0 in the cycle where frame_start=1; increments by 1 after each cycle with de=1; holds during blanking.
  - Registered and aligned with o_de; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - typedef struct packed timing_t {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp : 12 bits each; h_pol, v_pol : 1 bit}.
  - Constants TIMING_640X480_60 = {640,16,96,48, 480,10,2,33, 0,0}.
  - Constants TIMING_800X600_60 = {800,40,128,88, 600,1,4,23, 1,1}.
  - Function total_h/total_v.
  - FSM state enum.
- One sub-module, vga_axis_cnt: a single-axis counter plus sync/active decoder, instantiated for H (advance every cycle) and for V (advance on H wrap).

Test Plan:
- Reset, i_en=1, i_mode=0 -> first active cycle shows (0,0), de=1, frame_start=1; hsync low exactly for Sx 656..751; line period 800 cycles; frame period 420000 cycles; vsync low exactly for Sy 490..491.
- i_en=1, i_mode=1 from reset -> line period 1056, hsync high for Sx 840..967, vsync high for Sy 601..604, frame period 663168 cycles.
- Running mode 0, toggle i_mode=1 at Sy=100 -> o_mode_pending=1 until the frame wraps; next cycle shows o_mode=1, (0,0), frame_start=1, and 1056-cycle lines from then on.
- i_en dropped at Sy=200 -> counting continues to (799,524), then S_IDLE; de stays 0 and Sx=Sy=0 held. Re-enable -> frame_start on the following cycle.
- i_rst asserted at (300,250) -> next cycle outputs equal reset values. Release with i_en=1 -> restart from (0,0).
- With VGA_PIXEL_ADDR_EN, mode 0 -> o_addr=639 at (639,0), 640 at (0,1), 307199 at (639,479), then 0 at the next frame_start.
